// File: rtl/prefix_add_seq_if.sv
// Request/result handshake bundle for the sequenced wide adder/subtractor.
// The master side issues operations and consumes results; the slave side is the adder.
interface prefix_add_seq_if #(
    parameter int Width = 8,
    parameter int Words = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     sub;
    logic [Width*Words-1:0]   op_a;
    logic [Width*Words-1:0]   op_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [Width*Words-1:0]   sum;
    logic                     co;
    logic                     ovf;

    modport master (
        output in_valid, sub, op_a, op_b, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, sub, op_a, op_b, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/prefix_add_seq.sv
// Wide add/sub built from one Kogge-Stone slice adder reused over Words slices,
// LSB slice first, with the slice carry registered between cycles.
module prefix_add_seq #(
    parameter int Width = 8,
    parameter int Words = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    prefix_add_seq_if.slave   bus
);
    localparam int N    = Width * Words;
    localparam int IdxW = $clog2(Words);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Parallel-prefix slice add; the carry-in is folded into bit 0's generate so
    // every prefix carry already includes it. Returns {carry_out, sum}.
    function automatic logic [Width:0] prefix_add(input logic [Width-1:0] a,
                                                  input logic [Width-1:0] b,
                                                  input logic             ci);
        logic [Width-1:0] g;
        logic [Width-1:0] p;
        logic [Width-1:0] gg;
        logic [Width-1:0] pp;
        logic [Width-1:0] g_n;
        logic [Width-1:0] p_n;
        logic [Width-1:0] s;
        g     = a & b;
        p     = a ^ b;
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & ci);
        for (int d = 1; d < Width; d = d * 2) begin
            g_n = gg;
            p_n = pp;
            for (int i = d; i < Width; i++) begin
                g_n[i] = gg[i] | (pp[i] & gg[i-d]);
                p_n[i] = pp[i] & pp[i-d];
            end
            gg = g_n;
            pp = p_n;
        end
        s = p ^ {gg[Width-2:0], ci};
        return {gg[Width-1], s};
    endfunction

    state_t           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic [N-1:0]     sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    int               base_s;
    logic [Width-1:0] a_slice_s;
    logic [Width-1:0] b_slice_s;
    logic [Width:0]   slice_res_s;

    // Next-state, slice datapath and handshake flag computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        base_s      = int'(idx_q) * Width;
        a_slice_s   = a_q[base_s +: Width];
        b_slice_s   = b_q[base_s +: Width];
        slice_res_s = prefix_add(a_slice_s, b_slice_s, carry_q);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.sub ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub;
                    idx_d   = {IdxW{1'b0}};
                    sum_d   = {N{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[base_s +: Width] = slice_res_s[Width-1:0];
                if (idx_q == IdxW'(Words - 1)) begin
                    co_d    = slice_res_s[Width];
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (slice_res_s[Width-1] != a_q[N-1]);
                    state_d = S_DONE;
                end else begin
                    carry_d = slice_res_s[Width];
                    idx_d   = idx_q + IdxW'(1);
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= {IdxW{1'b0}};
            carry_q     <= 1'b0;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            sum_q       <= {N{1'b0}};
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prefix_add_seq.sv
// Directed and random bench for prefix_add_seq: an arithmetic reference model
// checked every cycle, plus literal expectations for the hand-worked cases.
module tb_prefix_add_seq;
    localparam int W  = 8;
    localparam int WD = 4;
    localparam int N  = W * WD;

    logic clk;
    logic reset_n;

    prefix_add_seq_if #(.Width(W), .Words(WD)) bus ();

    prefix_add_seq #(.Width(W), .Words(WD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: result is plain wide arithmetic; timing is "busy for WD edges, then done".
    logic [N-1:0] m_sum;
    logic         m_co;
    logic         m_ovf;
    int           m_left;
    bit           m_busy;
    bit           m_done;

    always @(posedge clk) begin
        logic [N-1:0] bb;
        logic [N:0]   full;
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_sum  = '0;
            m_co   = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (bus.in_valid) begin
            bb     = bus.sub ? ~bus.op_b : bus.op_b;
            full   = {1'b0, bus.op_a} + {1'b0, bb} + {{N{1'b0}}, bus.sub};
            m_sum  = full[N-1:0];
            m_co   = full[N];
            m_ovf  = (bus.op_a[N-1] == bb[N-1]) && (m_sum[N-1] != bus.op_a[N-1]);
            m_busy = 1'b1;
            m_left = WD;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every visible output against the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            chk("in_ready", 64'(bus.in_ready), 64'(!m_busy && !m_done));
            chk("out_valid", 64'(bus.out_valid), 64'(m_done));
            if (m_done) begin
                chk("model_sum", 64'(bus.sum), 64'(m_sum));
                chk("model_co", 64'(bus.co), 64'(m_co));
                chk("model_ovf", 64'(bus.ovf), 64'(m_ovf));
            end
        end
    endtask

    task automatic start_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.sub      = s;
        bus.op_a     = a;
        bus.op_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.op_a     = N'({$urandom, $urandom});
        bus.op_b     = N'({$urandom, $urandom});
    endtask

    task automatic wait_result();
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'(WD));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'd0);
        chk("ready_back", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic directed(input string name, input logic s, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [N-1:0] es,
                            input logic eco, input logic eovf);
        start_op(s, a, b);
        wait_result();
        chk({name, "_sum"}, 64'(bus.sum), 64'(es));
        chk({name, "_co"}, 64'(bus.co), 64'(eco));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(eovf));
        release_result();
    endtask

    initial begin
        logic [N-1:0] edge_vals [6];
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           stall;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sub       = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_co", 64'(bus.co), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick();

        directed("add_ff_1", 1'b0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0);
        directed("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_5_7", 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_7_5", 1'b1, 32'h0000_0007, 32'h0000_0005, 32'h0000_0002, 1'b1, 1'b0);
        directed("add_ovf", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_ovf", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Result held through a consumer stall while new requests are presented.
        start_op(1'b0, 32'h0000_00FF, 32'h0000_0001);
        wait_result();
        bus.in_valid = 1'b1;
        bus.op_a     = 32'h0000_0010;
        bus.op_b     = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_sum", 64'(bus.sum), 64'h100);
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("stall_exit_ready", 64'(bus.in_ready), 64'd1);
        chk("stall_exit_valid", 64'(bus.out_valid), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        wait_result();
        chk("stall_next_sum", 64'(bus.sum), 64'h30);
        release_result();

        // Reset while the third slice is being processed.
        start_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_sum", 64'(bus.sum), 64'd0);
        directed("after_rst", 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);

        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h00FF_00FF;
        edge_vals[5] = 32'h0000_0001;
        for (int k = 0; k < 300; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : N'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : N'($urandom);
            start_op(1'($urandom_range(0, 1)), ra, rb);
            wait_result();
            stall = $urandom_range(0, 3);
            for (int j = 0; j < stall; j++) tick();
            release_result();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
